// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM states, port index type, round-robin helper.
package mem_port_arbiter_pkg;

  localparam int unsigned MEM_ARB_MAX_PORTS = 8;
  localparam int unsigned MEM_ARB_IDX_W     = $clog2(MEM_ARB_MAX_PORTS);

  typedef logic [MEM_ARB_IDX_W-1:0] port_idx_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } arb_state_e;

  // Control half of a captured request; address/data widths are per-instance.
  typedef struct packed {
    logic      write;
    port_idx_t grant;
  } cap_ctrl_t;

  function automatic port_idx_t next_port(input port_idx_t cur, input int unsigned num_ports);
    if (32'(cur) + 32'd1 >= num_ports) return '0;
    return cur + 1'b1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping to port 0.
module mem_port_arbiter_rr_priority_picker
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  port_idx_t            rr_ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output port_idx_t            gnt_idx,
  output logic                 any_valid
);

  port_idx_t hi_idx;
  port_idx_t lo_idx;
  logic      hi_found;
  logic      lo_found;

  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int unsigned j = 0; j < NUM_PORTS; j++) begin
      if (req[j]) begin
        if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = port_idx_t'(j);
        end
        if (!hi_found && j >= 32'(rr_ptr)) begin
          hi_found = 1'b1;
          hi_idx   = port_idx_t'(j);
        end
      end
    end
    any_valid = lo_found;
    // Nothing at/after the pointer means the wrapped search wins.
    gnt_idx   = hi_found ? hi_idx : lo_idx;
    gnt       = '0;
    for (int unsigned j = 0; j < NUM_PORTS; j++) begin
      gnt[j] = any_valid && (32'(gnt_idx) == j);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter of NUM_PORTS cache-line requesters onto one external memory port.
// Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned LINE_WORDS     = 4,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic [NUM_PORTS-1:0]             i_req,
  input  logic [NUM_PORTS-1:0]             i_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  i_addr,
  input  logic [NUM_PORTS*LINE_WORDS*32-1:0] i_wdata,
  output logic [NUM_PORTS-1:0]             o_done,
  output logic [LINE_WORDS*32-1:0]         o_rdata,
  output logic [NUM_PORTS-1:0]             o_error,
  output logic                             o_busy,
  output logic                             o_mem_read,
  output logic                             o_mem_write,
  output logic [ADDR_WIDTH-1:0]            o_mem_addr,
  output logic [LINE_WORDS*32-1:0]         o_mem_wdata,
  input  logic                             i_mem_ready,
  input  logic [LINE_WORDS*32-1:0]         i_mem_rdata
);

  localparam int unsigned LineW = LINE_WORDS * 32;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [LineW-1:0]      wdata;
    logic [NUM_PORTS-1:0]  grant_oh;
    cap_ctrl_t             ctrl;
  } cap_req_t;

  arb_state_e           state_q, state_d;
  port_idx_t            rr_ptr_q, rr_ptr_d;
  cap_req_t             cap_q, cap_d;
  logic [LineW-1:0]     rdata_q, rdata_d;

  logic [NUM_PORTS-1:0]  pick_gnt;
  port_idx_t             pick_idx;
  logic                  pick_any;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [LineW-1:0]      sel_wdata;
  logic                  sel_write;
  logic                  in_cmd_state;
  logic                  timeout_hit;

  mem_port_arbiter_rr_priority_picker #(
    .NUM_PORTS (NUM_PORTS)
  ) u_picker (
    .req       (i_req),
    .rr_ptr    (rr_ptr_q),
    .gnt       (pick_gnt),
    .gnt_idx   (pick_idx),
    .any_valid (pick_any)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (32'(pick_idx) == k) begin
        sel_addr  = i_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = i_wdata[k*LineW +: LineW];
        sel_write = i_write[k];
      end
    end
  end

  assign in_cmd_state = (state_q == StIssue) || (state_q == StWait);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] wd_cnt_q, wd_cnt_d;

  // Zero in every non-command state, so each ISSUE entry starts from 0.
  always_comb begin
    wd_cnt_d = '0;
    if (in_cmd_state) wd_cnt_d = wd_cnt_q + 1'b1;
  end

  assign timeout_hit = in_cmd_state && !i_mem_ready && (wd_cnt_q == CntW'(TIMEOUT_CYCLES));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) wd_cnt_q <= '0;
    else         wd_cnt_q <= wd_cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cap_d    = cap_q;
    rdata_d  = rdata_q;
    case (state_q)
      StIdle: begin
        if (pick_any) begin
          cap_d.addr       = sel_addr;
          cap_d.wdata      = sel_wdata;
          cap_d.grant_oh   = pick_gnt;
          cap_d.ctrl.write = sel_write;
          cap_d.ctrl.grant = pick_idx;
          state_d          = StIssue;
        end
      end
      StIssue, StWait: begin
        if (i_mem_ready) begin
          if (!cap_q.ctrl.write) rdata_d = i_mem_rdata;
          state_d = StResp;
        end else if (timeout_hit) begin
          rr_ptr_d = next_port(cap_q.ctrl.grant, NUM_PORTS);
          state_d  = StIdle;
        end else begin
          state_d = StWait;
        end
      end
      StResp: begin
        rr_ptr_d = next_port(cap_q.ctrl.grant, NUM_PORTS);
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      cap_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cap_q    <= cap_d;
      rdata_q  <= rdata_d;
    end
  end

  assign o_mem_read  = in_cmd_state && !timeout_hit && !cap_q.ctrl.write;
  assign o_mem_write = in_cmd_state && !timeout_hit && cap_q.ctrl.write;
  assign o_mem_addr  = cap_q.addr;
  assign o_mem_wdata = cap_q.wdata;
  assign o_rdata     = rdata_q;
  assign o_busy      = (state_q != StIdle);
  assign o_done      = (state_q == StResp) ? cap_q.grant_oh : '0;
  assign o_error     = timeout_hit ? cap_q.grant_oh : '0;

endmodule
